// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Sequencing controller for a 5-stage pipeline: load-use stalls,
//           jump/redirect flushes, memory-wait freeze, halt/drain, counters.
// Rev     : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_opcode,
  input  logic [2:0]       id_funct,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNQ   = 4'b0111;
  localparam logic [3:0] OP_J     = 4'b1001;
  localparam logic [3:0] OP_JAL   = 4'b1010;

  localparam logic [1:0] SEL_SEQ   = 2'b00;
  localparam logic [1:0] SEL_JUMP  = 2'b01;
  localparam logic [1:0] SEL_REDIR = 2'b10;

  localparam logic [2:0]       DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           ctx;
  logic [2:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic uses_rs, uses_rt, id_jump, load_use, mem_wait;
  logic unused_funct;

  // funct does not affect hazard decisions; only the opcode class matters
  assign unused_funct = ^id_funct;

  always_comb begin
    uses_rs  = (id_opcode != OP_J) && (id_opcode != OP_JAL);
    uses_rt  = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) ||
               (id_opcode == OP_BEQ)   || (id_opcode == OP_BNQ);
    id_jump  = (id_opcode == OP_J) || (id_opcode == OP_JAL);
    load_use = ex_mem_read && (ex_rt != 3'd0) &&
               ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
    mem_wait = mem_access && !dmem_ready;
  end

  // MEM_WAIT behaves as its return state once memory stops waiting
  assign ctx    = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
  assign halted = (state_q == ST_HALTED);

  always_comb begin
    pc_en        = 1'b1;
    pc_sel       = SEL_SEQ;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    drain_d      = drain_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (mem_wait) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      if (ctx != ST_HALTED) begin
        state_d = ST_MEM_WAIT;
        ret_d   = ctx;
      end
    end else begin
      case (ctx)
        ST_RUN: begin
          state_d = ST_RUN;
          if (ex_redirect) begin
            pc_sel      = SEL_REDIR;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_jump) begin
            pc_sel      = SEL_JUMP;
            if_id_flush = 1'b1;
          end
          if (halt_req) begin
            state_d = ST_DRAIN;
            drain_d = 3'd0;
          end
        end
        ST_DRAIN: begin
          state_d     = ST_DRAIN;
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          if (ex_redirect) begin
            pc_en       = 1'b1;
            pc_sel      = SEL_REDIR;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_jump) begin
            pc_en  = 1'b1;
            pc_sel = SEL_JUMP;
          end
          if (ex_redirect || !load_use) begin
            drain_d = drain_q + 3'd1;
            if (drain_q == DRAIN_LAST) begin
              state_d = ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          if (!halt_req) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    // Freeze cycles while returning to RUN still count as RUN stalls
    if (ctx == ST_RUN) begin
      if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      drain_q     <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench for pipeline_hazard_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  id_opcode;
  logic [2:0]  id_funct, id_rs, id_rt, ex_rt;
  logic        ex_mem_read, ex_redirect, mem_access, dmem_ready, halt_req;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_flush, halted;
  logic [1:0]  pc_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, halted}
  localparam logic [9:0] NORM = 10'b1_00_1_0_1_0_1_0_0;
  localparam logic [9:0] LU   = 10'b0_00_0_0_1_1_1_0_0;
  localparam logic [9:0] JMP  = 10'b1_01_1_1_1_0_1_0_0;
  localparam logic [9:0] RED  = 10'b1_10_1_1_1_1_1_0_0;
  localparam logic [9:0] FRZ  = 10'b0_00_0_0_0_0_0_1_0;
  localparam logic [9:0] DRN  = 10'b0_00_1_1_1_0_1_0_0;
  localparam logic [9:0] HLT  = 10'b0_00_1_1_1_0_1_0_1;

  logic [9:0] outs;
  assign outs = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, mem_wb_flush, halted};

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic mr, input logic [2:0] ert, input logic redir,
                       input logic macc, input logic rdy, input logic hreq);
    id_opcode = op; id_funct = 3'd0; id_rs = rs; id_rt = rt;
    ex_mem_read = mr; ex_rt = ert; ex_redirect = redir;
    mem_access = macc; dmem_ready = rdy; halt_req = hreq;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [9:0] exp);
    chk(tag, {22'd0, outs}, {22'd0, exp});
    tick();
  endtask

  task automatic cnts(input string tag, input logic [15:0] s, input logic [15:0] f);
    chk({tag, "_stall"}, {16'd0, stall_cnt}, {16'd0, s});
    chk({tag, "_flush"}, {16'd0, flush_cnt}, {16'd0, f});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0);
    chk("reset_outs", {22'd0, outs}, {22'd0, NORM});
    cnts("reset", 16'd0, 16'd0);
    #1 rst_n = 1'b1;
    tick();

    // load-use on rs, then bubble, then load into r0
    drive(4'h0, 3'd2, 3'd1, 1, 3'd2, 0, 0, 1, 0);
    step("lu_rs", LU);
    cnts("after_lu", 16'd1, 16'd0);
    drive(4'h0, 3'd2, 3'd1, 0, 3'd2, 0, 0, 1, 0);
    step("lu_bubble", NORM);
    drive(4'h0, 3'd0, 3'd1, 1, 3'd0, 0, 0, 1, 0);
    step("lu_r0", NORM);
    // load-use through rt of SW; J ignores rs
    drive(4'h2, 3'd5, 3'd3, 1, 3'd3, 0, 0, 1, 0);
    step("lu_sw_rt", LU);
    drive(4'h9, 3'd3, 3'd0, 1, 3'd3, 0, 0, 1, 0);
    step("j_no_rs", JMP);
    cnts("after_j", 16'd2, 16'd1);

    drive(4'hA, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0);
    step("jal", JMP);
    drive(4'hA, 3'd0, 3'd0, 0, 3'd0, 1, 0, 1, 0);
    step("jal_redir", RED);
    drive(4'h0, 3'd2, 3'd0, 1, 3'd2, 1, 0, 1, 0);
    step("redir_lu", RED);
    cnts("after_redir", 16'd2, 16'd4);

    // three-cycle memory wait, resume in the ready cycle
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0);
      step("freeze", FRZ);
    end
    cnts("after_freeze", 16'd5, 16'd4);
    drive(4'h9, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 0);
    step("resume_jump", JMP);
    cnts("after_resume", 16'd5, 16'd5);

    // plain halt/drain
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 1);
    step("halt_c0", NORM);
    for (int i = 0; i < 4; i++) step("drain", DRN);
    step("halted", HLT);
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0);
    step("halted_rel", HLT);
    step("resume_run", NORM);
    cnts("after_halt", 16'd5, 16'd5);

    // drain stretched by a load-use and a two-cycle memory wait
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 1);
    step("h2_c0", NORM);
    step("h2_d1", DRN);
    drive(4'h0, 3'd2, 3'd0, 1, 3'd2, 0, 0, 1, 1);
    step("h2_lu", LU);
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0);
    step("h2_frz1", FRZ);
    step("h2_frz2", FRZ);
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, 0);
    step("h2_d2", DRN);
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 1, 0, 1, 0);
    step("h2_redir", RED);
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0);
    step("h2_d4", DRN);
    step("h2_halted", HLT);
    step("h2_run", NORM);
    cnts("after_h2", 16'd5, 16'd5);

    // async reset while frozen in MEM_WAIT
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0);
    step("mw_frz1", FRZ);
    cnts("mw_cnt", 16'd6, 16'd5);
    chk("mw_frz2", {22'd0, outs}, {22'd0, FRZ});
    drive(4'h0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    cnts("async_rst", 16'd0, 16'd0);
    chk("async_rst_outs", {22'd0, outs}, {22'd0, NORM});
    rst_n = 1'b1;
    tick();
    step("post_rst", NORM);

    // stall counter saturation
    drive(4'h0, 3'd2, 3'd0, 1, 3'd2, 0, 0, 1, 0);
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_outs", {22'd0, outs}, {22'd0, LU});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
